spi_ram_master: RTL and testbench



---
 rtl/spi_ram_master.sv | 256 +++++++++++++++++++++++++
 tb/tb_spi_ram_master.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_master.sv
// ---------------------------------------------------------------------------
// spi_ram_master
//
// Host-side SPI master (mode 0) for the SPI RAM slave. Each accepted host
// command becomes one SPI frame carrying the 10-bit word {op, data}, MSB first.
// Read-data frames (op 2'b11) then run TURN_CYCLES idle SCLK periods and
// clock eight more periods to capture the RAM byte from MISO.
//
// Frame sequence: IDLE -> SETUP -> TX -> (TURN -> RX, read-data only)
//                 -> HOLD -> GAP -> IDLE
//
// Parameters
//   CLK_DIV      SCLK half-period in clk cycles (>= 1)
//   TURN_CYCLES  idle SCLK periods between last MOSI bit and first MISO bit
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   cmd_valid    host command request
//   cmd_ready    high only in IDLE; accept = cmd_valid && cmd_ready
//   cmd_op       00 write-addr, 01 write-data, 10 read-addr, 11 read-data
//   cmd_data     address/data byte (shifted out for every op)
//   rsp_valid    one-cycle pulse when a read-data byte is available
//   rsp_data     last byte read, held until the next read-data completes
//   busy         inverse of cmd_ready
//   sclk         SPI clock, idle low
//   ss_n         slave select, active low
//   mosi         serial data to slave
//   miso         serial data from slave
// ---------------------------------------------------------------------------
module spi_ram_master #(
  parameter int CLK_DIV     = 2,
  parameter int TURN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       sclk,
  output logic       ss_n,
  output logic       mosi,
  input  logic       miso
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PER_MAX = (TURN_CYCLES > 10) ? TURN_CYCLES : 10;
  localparam int PER_W  = $clog2(PER_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [PER_W-1:0] TX_LAST   = PER_W'(9);
  localparam logic [PER_W-1:0] RX_LAST   = PER_W'(7);
  // Only compared against while in TURN, which is skipped when TURN_CYCLES=0.
  localparam logic [PER_W-1:0] TURN_LAST = PER_W'(TURN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_TX,
    S_TURN,
    S_RX,
    S_HOLD,
    S_GAP
  } state_e;

  state_e           state_q,     state_d;
  logic [DIV_W-1:0] div_q,       div_d;       // clk cycles within a phase
  logic [PER_W-1:0] per_q,       per_d;       // SCLK periods within a state
  logic [9:0]       shift_q,     shift_d;     // outgoing word, bit 9 on mosi
  logic [7:0]       rx_q,        rx_d;        // incoming byte
  logic             rd_op_q,     rd_op_d;     // frame is a read-data frame
  logic             sclk_q,      sclk_d;
  logic             ss_n_q,      ss_n_d;
  logic             mosi_q,      mosi_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_data_q,  rsp_data_d;

  logic phase_end;

  assign phase_end = (div_q == DIV_LAST);

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    div_d       = div_q + 1'b1;
    per_d       = per_q;
    shift_d     = shift_q;
    rx_d        = rx_q;
    rd_op_d     = rd_op_q;
    sclk_d      = sclk_q;
    ss_n_d      = ss_n_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (cmd_valid) begin
          state_d = S_SETUP;
          shift_d = {cmd_op, cmd_data};
          rd_op_d = (cmd_op == 2'b11);
          per_d   = '0;
          ss_n_d  = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = cmd_op[1];
        end
      end

      S_SETUP: begin
        if (phase_end) begin
          div_d   = '0;
          state_d = S_TX;
          sclk_d  = 1'b1;
        end
      end

      S_TX: begin
        if (phase_end) begin
          div_d = '0;
          if (sclk_q) begin
            // Falling edge: present the next bit, or park mosi after bit 0.
            sclk_d = 1'b0;
            if (per_q == TX_LAST) begin
              mosi_d = 1'b0;
              // Write/addr frames finish bit 0's low phase in HOLD; read-data
              // frames finish it here and roll into TURN/RX.
              if (!rd_op_q) state_d = S_HOLD;
            end else begin
              mosi_d  = shift_q[8];
              shift_d = {shift_q[8:0], 1'b0};
            end
          end else begin
            sclk_d = 1'b1;
            if (per_q == TX_LAST) begin
              per_d   = '0;
              state_d = (TURN_CYCLES == 0) ? S_RX : S_TURN;
            end else begin
              per_d = per_q + 1'b1;
            end
          end
        end
      end

      S_TURN: begin
        if (phase_end) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            if (per_q == TURN_LAST) begin
              per_d   = '0;
              state_d = S_RX;
            end else begin
              per_d = per_q + 1'b1;
            end
          end
        end
      end

      S_RX: begin
        if (phase_end) begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            // The last period's low phase is spent in HOLD.
            if (per_q == RX_LAST) state_d = S_HOLD;
          end else begin
            sclk_d = 1'b1;
            per_d  = per_q + 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (phase_end) begin
          div_d   = '0;
          state_d = S_GAP;
          ss_n_d  = 1'b1;
          if (rd_op_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rx_q;
          end
        end
      end

      S_GAP: begin
        if (phase_end) begin
          div_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        div_d   = '0;
        sclk_d  = 1'b0;
        ss_n_d  = 1'b1;
        mosi_d  = 1'b0;
      end
    endcase

    // MISO is captured in the cycle SCLK rises during RX.
    if (state_d == S_RX && !sclk_q && sclk_d) begin
      rx_d = {rx_q[6:0], miso};
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      per_q       <= '0;
      shift_q     <= '0;
      rx_q        <= '0;
      rd_op_q     <= 1'b0;
      sclk_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      per_q       <= per_d;
      shift_q     <= shift_d;
      rx_q        <= rx_d;
      rd_op_q     <= rd_op_d;
      sclk_q      <= sclk_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = ~cmd_ready;
  assign sclk      = sclk_q;
  assign ss_n      = ss_n_q;
  assign mosi      = mosi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// ---------------------------------------------------------------------------
// tb_spi_ram_master
//
// Two DUT instances: [0] CLK_DIV=2, TURN_CYCLES=2 and [1] CLK_DIV=1,
// TURN_CYCLES=0. Each has an SPI RAM slave model that decodes MOSI frames
// into its own memory and answers read-data frames on MISO (random noise
// elsewhere). A host-level reference RAM predicts every frame word and read
// response; monitors compare frames (word, rising-edge count, ss_n low time,
// inter-frame gap) and responses as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_spi_ram_master;

  typedef struct {
    logic [9:0] word;
    bit         rd;
    bit         abort;
    int         exp_gap;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n     [2];
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic [1:0] cmd_op    [2];
  logic [7:0] cmd_data  [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_data  [2];
  logic       busy      [2];
  logic       sclk      [2];
  logic       ss_n      [2];
  logic       mosi      [2];
  logic       miso      [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard queues
  frame_t     frame_q [2][$];
  logic [7:0] rsp_q   [2][$];

  // Host-level reference RAM
  logic [7:0] ref_mem  [2][256];
  logic [7:0] ref_addr [2];
  logic [7:0] last_rsp [2];

  // SPI slave model state
  logic [7:0] slave_mem  [2][256];
  logic [7:0] slave_addr [2];
  int         s_edges    [2];
  logic [9:0] s_word     [2];
  logic [7:0] s_rd_byte  [2];

  always #5 clk = ~clk;

  spi_ram_master #(.CLK_DIV(2), .TURN_CYCLES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .cmd_data(cmd_data[0]), .rsp_valid(rsp_valid[0]),
    .rsp_data(rsp_data[0]), .busy(busy[0]), .sclk(sclk[0]), .ss_n(ss_n[0]),
    .mosi(mosi[0]), .miso(miso[0])
  );

  spi_ram_master #(.CLK_DIV(1), .TURN_CYCLES(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .cmd_data(cmd_data[1]), .rsp_valid(rsp_valid[1]),
    .rsp_data(rsp_data[1]), .busy(busy[1]), .sclk(sclk[1]), .ss_n(ss_n[1]),
    .mosi(mosi[1]), .miso(miso[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Per-instance slave model and monitors
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : g_side
    localparam int TC  = (g == 0) ? 2 : 0;
    localparam int CDV = (g == 0) ? 2 : 1;

    frame_t cur;
    bit     have_cur = 1'b0;
    bit     prev_ss  = 1'b1;
    int     lo_len   = 0;
    int     hi_len   = 0;

    always @(negedge ss_n[g]) begin
      s_edges[g] = 0;
      s_word[g]  = '0;
    end

    always @(posedge sclk[g]) begin
      check($sformatf("i%0d_sclk_only_when_selected", g), ss_n[g], 1'b0);
      s_edges[g] = s_edges[g] + 1;
      if (s_edges[g] <= 10) s_word[g] = {s_word[g][8:0], mosi[g]};
      if (s_edges[g] == 10) s_rd_byte[g] = slave_mem[g][slave_addr[g]];
    end

    // Slave drives its byte on the falling edges that follow the turnaround.
    always @(negedge sclk[g]) begin
      if (!ss_n[g] && s_word[g][9:8] == 2'b11 &&
          s_edges[g] >= 10 + TC && s_edges[g] <= 17 + TC)
        miso[g] = s_rd_byte[g][17 + TC - s_edges[g]];
      else
        miso[g] = 1'($urandom_range(0, 1));
    end

    always @(posedge ss_n[g]) begin
      if (s_edges[g] == 10) begin
        case (s_word[g][9:8])
          2'b00, 2'b10: slave_addr[g] = s_word[g][7:0];
          2'b01:        slave_mem[g][slave_addr[g]] = s_word[g][7:0];
          default: ;
        endcase
      end
    end

    // Frame monitor
    always @(negedge clk) begin
      if (ss_n[g] == 1'b0) begin
        if (prev_ss) begin
          check($sformatf("i%0d_frame_expected", g), 32'(frame_q[g].size() != 0), 1);
          check($sformatf("i%0d_busy_ready_in_frame", g), {busy[g], cmd_ready[g]}, 2'b10);
          have_cur = (frame_q[g].size() != 0);
          if (have_cur) begin
            cur = frame_q[g].pop_front();
            if (cur.exp_gap != 0)
              check($sformatf("i%0d_ss_high_gap", g), hi_len, cur.exp_gap);
          end
          lo_len = 0;
        end
        lo_len++;
      end else begin
        if (!prev_ss && have_cur && !cur.abort) begin
          check($sformatf("i%0d_word", g), s_word[g], cur.word);
          check($sformatf("i%0d_rise_edges", g), s_edges[g], cur.rd ? 18 + TC : 10);
          check($sformatf("i%0d_ss_low_cycles", g), lo_len,
                cur.rd ? (21 + 2 * (TC + 8)) * CDV : 21 * CDV);
        end
        if (!prev_ss) have_cur = 1'b0;
        hi_len = prev_ss ? hi_len + 1 : 1;
      end
      prev_ss = ss_n[g];
    end

    // Response monitor
    always @(negedge clk) begin
      if (rsp_valid[g] === 1'b1) begin
        check($sformatf("i%0d_rsp_expected", g), 32'(rsp_q[g].size() != 0), 1);
        if (rsp_q[g].size() != 0)
          check($sformatf("i%0d_rsp_data", g), rsp_data[g], rsp_q[g].pop_front());
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  // Returns right after the accepting clock edge with cmd_valid still high.
  task automatic send(input int g, input logic [1:0] op, input logic [7:0] data,
                      input bit abort, input int gap);
    frame_t f;
    int     n = 0;
    @(negedge clk);
    cmd_valid[g] = 1'b1;
    cmd_op[g]    = op;
    cmd_data[g]  = data;
    while (!cmd_ready[g] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready[g]) begin
      check($sformatf("i%0d_accept_timeout", g), cmd_ready[g], 1'b1);
      cmd_valid[g] = 1'b0;
      return;
    end
    @(posedge clk);
    f.word    = {op, data};
    f.rd      = (op == 2'b11);
    f.abort   = abort;
    f.exp_gap = gap;
    frame_q[g].push_back(f);
    case (op)
      2'b00, 2'b10: ref_addr[g] = data;
      2'b01:        ref_mem[g][ref_addr[g]] = data;
      default: if (!abort) begin
        rsp_q[g].push_back(ref_mem[g][ref_addr[g]]);
        last_rsp[g] = ref_mem[g][ref_addr[g]];
      end
    endcase
  endtask

  task automatic release_cmd(input int g);
    @(negedge clk);
    cmd_valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    while (!(cmd_ready[g] && ss_n[g]) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!(cmd_ready[g] && ss_n[g])) check($sformatf("i%0d_idle_timeout", g), cmd_ready[g], 1'b1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    int cnt;
    int n;

    for (int g = 0; g < 2; g++) begin
      rst_n[g]      = 1'b0;
      cmd_valid[g]  = 1'b0;
      cmd_op[g]     = '0;
      cmd_data[g]   = '0;
      miso[g]       = 1'b0;
      ref_addr[g]   = '0;
      slave_addr[g] = '0;
      last_rsp[g]   = '0;
      s_edges[g]    = 0;
      s_word[g]     = '0;
      s_rd_byte[g]  = '0;
      for (int i = 0; i < 256; i++) begin
        ref_mem[g][i]   = 8'(i) ^ 8'h5A;
        slave_mem[g][i] = 8'(i) ^ 8'h5A;
      end
    end

    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++)
      check($sformatf("i%0d_reset_state", g),
            {ss_n[g], sclk[g], mosi[g], rsp_valid[g], rsp_data[g], cmd_ready[g], busy[g]},
            {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (2) @(negedge clk);

    // Write-addr 0x3C: word 0x03C, 42 cycles of ss_n low, no response.
    send(0, 2'b00, 8'h3C, 1'b0, 0);
    release_cmd(0);
    wait_idle(0);

    // Back-to-back write-data 0xA5 then read-addr 0x3C with cmd_valid held.
    send(0, 2'b01, 8'hA5, 1'b0, 0);
    send(0, 2'b10, 8'h3C, 1'b0, 3);
    release_cmd(0);
    wait_idle(0);

    // Store 0x96 at 0x10, read it back, then check it survives a write frame.
    send(0, 2'b00, 8'h10, 1'b0, 0);
    send(0, 2'b01, 8'h96, 1'b0, 0);
    send(0, 2'b10, 8'h10, 1'b0, 0);
    send(0, 2'b11, 8'($urandom), 1'b0, 0);
    release_cmd(0);
    wait_idle(0);
    send(0, 2'b00, 8'h77, 1'b0, 0);
    release_cmd(0);
    wait_idle(0);
    check("i0_rsp_data_held", rsp_data[0], last_rsp[0]);

    // cmd_valid pulsed mid-frame is ignored; busy lasts ss-low + CLK_DIV + 1.
    send(0, 2'b00, 8'h5A, 1'b0, 0);
    cnt = 1;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    while (!cmd_ready[0] && cnt < 500) begin
      cnt++;
      if (cnt == 8) begin
        cmd_valid[0] = 1'b1;
        cmd_op[0]    = 2'b01;
        cmd_data[0]  = 8'hFF;
      end else begin
        cmd_valid[0] = 1'b0;
      end
      @(negedge clk);
    end
    cmd_valid[0] = 1'b0;
    check("i0_accept_to_ready_cycles", cnt, 21 * 2 + 2 + 1);
    wait_idle(0);

    // Reset in the middle of RX, after four MISO bits have been sampled.
    send(0, 2'b11, 8'h00, 1'b1, 0);
    release_cmd(0);
    n = 0;
    while (s_edges[0] < 13 + 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("i0_reached_rx", 32'(s_edges[0] >= 16), 1);
    rst_n[0] = 1'b0;
    #1;
    check("i0_abort_pins", {ss_n[0], sclk[0], rsp_valid[0], rsp_data[0]},
          {1'b1, 1'b0, 1'b0, 8'h00});
    last_rsp[0] = 8'h00;
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    repeat (2) @(negedge clk);
    send(0, 2'b00, 8'h3C, 1'b0, 0);
    release_cmd(0);
    wait_idle(0);
    check("i0_rsp_data_after_abort", rsp_data[0], last_rsp[0]);

    // CLK_DIV=1, TURN_CYCLES=0 read-data frame: 37 low cycles, 18 edges.
    send(1, 2'b00, 8'h20, 1'b0, 0);
    send(1, 2'b01, 8'hC3, 1'b0, 0);
    send(1, 2'b10, 8'h20, 1'b0, 2);
    send(1, 2'b11, 8'hFF, 1'b0, 2);
    release_cmd(1);
    wait_idle(1);
    check("i1_rsp_data_held", rsp_data[1], last_rsp[1]);

    // Random command streams, some back-to-back.
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 24; i++) begin
        send(g, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 15)), 1'b0, 0);
        if ($urandom_range(0, 1) == 1) release_cmd(g);
      end
      release_cmd(g);
      wait_idle(g);
      check($sformatf("i%0d_rsp_data_final", g), rsp_data[g], last_rsp[g]);
    end

    for (int g = 0; g < 2; g++) begin
      check($sformatf("i%0d_frames_left", g), frame_q[g].size(), 0);
      check($sformatf("i%0d_rsps_left", g), rsp_q[g].size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
